pipeline_hazard_controller: RTL and testbench

Stall/flush sequencer for the five-stage MIPS pipeline, sitting beside the ID/EX forwarding logic. It resolves the hazards forwarding cannot cover: load-use, HI/LO access while the multi-cycle mult/div unit is busy, data-memory wait states, and taken-branch squash. It drives the PC/IF-ID hold, ID/EX bubble insertion, IF-ID flush and the mult/div start strobe, and it owns the mult/div busy counter and memory-wait FSM.

---
 rtl/pipeline_hazard_controller_if.sv | 37 +++
 rtl/pipeline_hazard_controller.sv | 114 +++++++++++
 tb/tb_pipeline_hazard_controller.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_hazard_controller_if.sv
// Hazard-controller bundle: decode/execute/memory status in, pipeline control out.
// The pipeline drives the master side; the controller sits on the slave side.
interface pipeline_hazard_controller_if;
    logic [4:0] id_reg1;
    logic [4:0] id_reg2;
    logic       id_use1;
    logic       id_use2;
    logic [1:0] id_md_op;
    logic       id_reads_hilo;
    logic       ex_is_load;
    logic [4:0] ex_write_reg;
    logic       ex_branch_taken;
    logic       mem_req;
    logic       mem_ack;
    logic       stall_front;
    logic       stall_back;
    logic       idex_bubble;
    logic       ifid_flush;
    logic       md_start;
    logic       md_busy;
    logic       md_done;
    logic       mem_error;

    modport master (
        output id_reg1, id_reg2, id_use1, id_use2, id_md_op, id_reads_hilo,
               ex_is_load, ex_write_reg, ex_branch_taken, mem_req, mem_ack,
        input  stall_front, stall_back, idex_bubble, ifid_flush,
               md_start, md_busy, md_done, mem_error
    );

    modport slave (
        input  id_reg1, id_reg2, id_use1, id_use2, id_md_op, id_reads_hilo,
               ex_is_load, ex_write_reg, ex_branch_taken, mem_req, mem_ack,
        output stall_front, stall_back, idex_bubble, ifid_flush,
               md_start, md_busy, md_done, mem_error
    );
endinterface

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the 5-stage MIPS pipeline: load-use, HI/LO-vs-mult/div,
// data-memory wait states and taken-branch squash; owns the mult/div counter and memory-wait FSM.
module pipeline_hazard_controller #(
    parameter int MULT_CYCLES = 4,
    parameter int DIV_CYCLES  = 32,
    parameter int CNT_W       = 6,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic                         clk,
    input  logic                         rst,
    pipeline_hazard_controller_if.slave  bus
);

    localparam logic [0:0]       ST_RUN      = 1'b0;
    localparam logic [0:0]       ST_MEM_WAIT = 1'b1;
    localparam logic [7:0]       TIMEOUT_V   = 8'(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0] MULT_LOAD   = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD    = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    logic [0:0]       state_q, state_d;
    logic [7:0]       wait_cnt_q, wait_cnt_d;
    logic             mem_error_q, mem_error_d;
    logic [CNT_W-1:0] md_cnt_q, md_cnt_d;
    logic             md_busy_q, md_busy_d;
    logic             md_done_q, md_done_d;

    logic load_hz, md_op_valid, md_hz, mem_wait, md_start_c;
    logic stall_front_c, stall_back_c, idex_bubble_c, ifid_flush_c;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == TIMEOUT_V) ? v : v + 8'd1;
    endfunction

    always_comb begin
        load_hz = bus.ex_is_load && (bus.ex_write_reg != 5'd0) &&
                  ((bus.id_use1 && (bus.id_reg1 == bus.ex_write_reg)) ||
                   (bus.id_use2 && (bus.id_reg2 == bus.ex_write_reg)));
        md_op_valid = (bus.id_md_op == 2'b01) || (bus.id_md_op == 2'b10);
        md_hz       = md_busy_q && (bus.id_reads_hilo || md_op_valid);
        mem_wait    = (state_q == ST_RUN) ? (bus.mem_req && !bus.mem_ack) : !bus.mem_ack;
        md_start_c  = md_op_valid && !md_busy_q && !mem_wait &&
                      !bus.ex_branch_taken && !load_hz;
    end

    // A held EX stage re-presents its branch, so memory wait outranks the squash.
    always_comb begin
        stall_front_c = 1'b0;
        stall_back_c  = 1'b0;
        idex_bubble_c = 1'b0;
        ifid_flush_c  = 1'b0;
        if (mem_wait) begin
            stall_front_c = 1'b1;
            stall_back_c  = 1'b1;
        end else if (bus.ex_branch_taken) begin
            ifid_flush_c  = 1'b1;
            idex_bubble_c = 1'b1;
        end else if (load_hz || md_hz) begin
            stall_front_c = 1'b1;
            idex_bubble_c = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:      if (bus.mem_req && !bus.mem_ack) state_d = ST_MEM_WAIT;
            ST_MEM_WAIT: if (bus.mem_ack) state_d = ST_RUN;
            default:     state_d = ST_RUN;
        endcase

        wait_cnt_d  = (state_q == ST_MEM_WAIT) ? sat_inc(wait_cnt_q) : 8'd0;
        mem_error_d = mem_error_q ||
                      ((state_q == ST_MEM_WAIT) && (wait_cnt_q == TIMEOUT_V));

        // The counter runs free of stalls so the unit's latency stays fixed.
        md_cnt_d = md_cnt_q;
        if (md_start_c) begin
            md_cnt_d = (bus.id_md_op == 2'b01) ? MULT_LOAD : DIV_LOAD;
        end else if (md_cnt_q != '0) begin
            md_cnt_d = md_cnt_q - CNT_ONE;
        end
        md_busy_d = (md_cnt_d != '0);
        md_done_d = (md_cnt_q == CNT_ONE) && !md_start_c;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_RUN;
            wait_cnt_q  <= 8'd0;
            mem_error_q <= 1'b0;
            md_cnt_q    <= '0;
            md_busy_q   <= 1'b0;
            md_done_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            mem_error_q <= mem_error_d;
            md_cnt_q    <= md_cnt_d;
            md_busy_q   <= md_busy_d;
            md_done_q   <= md_done_d;
        end
    end

    assign bus.stall_front = stall_front_c && !rst;
    assign bus.stall_back  = stall_back_c  && !rst;
    assign bus.idex_bubble = idex_bubble_c && !rst;
    assign bus.ifid_flush  = ifid_flush_c  && !rst;
    assign bus.md_start    = md_start_c    && !rst;
    assign bus.md_busy     = md_busy_q;
    assign bus.md_done     = md_done_q;
    assign bus.mem_error   = mem_error_q;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed bench for pipeline_hazard_controller: a combinational vector table from the
// idle state, then hand-written multi-cycle sequences for mult/div, memory wait and reset.
module tb_pipeline_hazard_controller;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pipeline_hazard_controller_if bus();

    pipeline_hazard_controller #(
        .MULT_CYCLES(4),
        .DIV_CYCLES (32),
        .CNT_W      (6),
        .MEM_TIMEOUT(255)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic       ld;
        logic [4:0] wr;
        logic [4:0] r1;
        logic       u1;
        logic [4:0] r2;
        logic       u2;
        logic [1:0] op;
        logic       hilo;
        logic       br;
        logic       mreq;
        logic       mack;
        logic [4:0] exp;  // {stall_front, stall_back, idex_bubble, ifid_flush, md_start}
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic ld, input logic [4:0] wr, input logic [4:0] r1,
                                input logic u1, input logic [4:0] r2, input logic u2,
                                input logic [1:0] op, input logic hilo, input logic br,
                                input logic mreq, input logic mack, input logic [4:0] exp);
        vec_t v;
        v.ld = ld; v.wr = wr; v.r1 = r1; v.u1 = u1; v.r2 = r2; v.u2 = u2;
        v.op = op; v.hilo = hilo; v.br = br; v.mreq = mreq; v.mack = mack; v.exp = exp;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_ctl(input string name, input logic [4:0] exp);
        check(name, {27'd0, bus.stall_front, bus.stall_back, bus.idex_bubble,
                     bus.ifid_flush, bus.md_start}, {27'd0, exp});
    endtask

    task automatic idle_inputs();
        bus.id_reg1 = 5'd0; bus.id_reg2 = 5'd0; bus.id_use1 = 1'b0; bus.id_use2 = 1'b0;
        bus.id_md_op = 2'b00; bus.id_reads_hilo = 1'b0; bus.ex_is_load = 1'b0;
        bus.ex_write_reg = 5'd0; bus.ex_branch_taken = 1'b0;
        bus.mem_req = 1'b0; bus.mem_ack = 1'b0;
    endtask

    task automatic apply(input vec_t v);
        bus.ex_is_load = v.ld; bus.ex_write_reg = v.wr;
        bus.id_reg1 = v.r1; bus.id_use1 = v.u1; bus.id_reg2 = v.r2; bus.id_use2 = v.u2;
        bus.id_md_op = v.op; bus.id_reads_hilo = v.hilo; bus.ex_branch_taken = v.br;
        bus.mem_req = v.mreq; bus.mem_ack = v.mack;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        bus.id_md_op = 2'b01;
        bus.mem_req  = 1'b1;
        #12;
        chk_ctl("reset_ctl_forced_low", 5'b00000);
        check("reset_md_busy", bus.md_busy, 0);
        check("reset_md_done", bus.md_done, 0);
        check("reset_mem_error", bus.mem_error, 0);
        idle_inputs();
        next_cycle();
        rst = 1'b0;
        next_cycle();

        // ex: ld wr | id: r1 u1 r2 u2 op hilo | br mreq mack | exp
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 5'b00000));
        vecs.push_back(mk(1, 5, 5, 1, 0, 0, 2'b00, 0, 0, 0, 0, 5'b10100));
        vecs.push_back(mk(1, 5, 5, 0, 0, 0, 2'b00, 0, 0, 0, 0, 5'b00000));
        vecs.push_back(mk(1, 0, 0, 1, 0, 1, 2'b00, 0, 0, 0, 0, 5'b00000));
        vecs.push_back(mk(1, 7, 0, 0, 7, 1, 2'b00, 0, 0, 0, 0, 5'b10100));
        vecs.push_back(mk(1, 7, 0, 0, 7, 1, 2'b01, 0, 0, 0, 0, 5'b10100));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 2'b01, 0, 0, 0, 0, 5'b00001));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 2'b10, 0, 0, 0, 0, 5'b00001));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 2'b11, 0, 0, 0, 0, 5'b00000));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 2'b00, 1, 0, 0, 0, 5'b00000));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 2'b00, 0, 1, 0, 0, 5'b00110));
        vecs.push_back(mk(1, 9, 9, 1, 0, 0, 2'b10, 0, 1, 0, 0, 5'b00110));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 1, 0, 5'b11000));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 2'b01, 0, 1, 1, 0, 5'b11000));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 2'b01, 0, 0, 1, 1, 5'b00001));
        vecs.push_back(mk(0, 5, 5, 1, 0, 0, 2'b00, 0, 0, 0, 0, 5'b00000));
        vecs.push_back(mk(1, 3, 3, 1, 3, 1, 2'b00, 0, 0, 0, 0, 5'b10100));
        vecs.push_back(mk(1, 4, 6, 1, 2, 1, 2'b00, 0, 0, 0, 0, 5'b00000));

        // Inputs go idle before each edge so every vector sees the idle state.
        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i]);
            #2;
            chk_ctl($sformatf("vec%0d_ctl", i), vecs[i].exp);
            check($sformatf("vec%0d_busy", i), bus.md_busy, 0);
            idle_inputs();
            next_cycle();
        end

        // Load-use: one bubble, then the load has moved to MEM.
        bus.ex_is_load = 1'b1; bus.ex_write_reg = 5'd5; bus.id_reg1 = 5'd5; bus.id_use1 = 1'b1;
        #2;
        chk_ctl("loaduse_cycle0", 5'b10100);
        next_cycle();
        bus.ex_is_load = 1'b0; bus.ex_write_reg = 5'd0;
        #2;
        chk_ctl("loaduse_cycle1", 5'b00000);
        idle_inputs();
        next_cycle();

        // mult then mflo: 4 busy/stall cycles, done pulse, then issue.
        bus.id_md_op = 2'b01;
        #2;
        chk_ctl("mult_start", 5'b00001);
        check("mult_busy_c0", bus.md_busy, 0);
        next_cycle();
        bus.id_md_op = 2'b00; bus.id_reads_hilo = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            #2;
            check($sformatf("mult_busy_c%0d", c), bus.md_busy, (c <= 4) ? 1 : 0);
            check($sformatf("mult_done_c%0d", c), bus.md_done, (c == 5) ? 1 : 0);
            chk_ctl($sformatf("mult_ctl_c%0d", c), (c <= 4) ? 5'b10100 : 5'b00000);
            next_cycle();
        end
        idle_inputs();

        // Memory wait for 3 cycles, release on ack with no bubble.
        bus.mem_req = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #2;
            chk_ctl($sformatf("memwait_c%0d", c), 5'b11000);
            next_cycle();
        end
        bus.mem_ack = 1'b1;
        #2;
        chk_ctl("memwait_ack", 5'b00000);
        next_cycle();
        idle_inputs();
        #2;
        chk_ctl("memwait_back_run", 5'b00000);
        next_cycle();

        // Taken branch held off by a memory wait, then squashes once acked.
        bus.mem_req = 1'b1; bus.ex_branch_taken = 1'b1;
        #2;
        chk_ctl("br_memwait_run", 5'b11000);
        next_cycle();
        #2;
        chk_ctl("br_memwait_wait", 5'b11000);
        next_cycle();
        bus.mem_ack = 1'b1;
        #2;
        chk_ctl("br_after_ack", 5'b00110);
        next_cycle();
        idle_inputs();

        // Branch + load-use + div: squash wins, no start.
        bus.ex_branch_taken = 1'b1; bus.ex_is_load = 1'b1; bus.ex_write_reg = 5'd8;
        bus.id_reg2 = 5'd8; bus.id_use2 = 1'b1; bus.id_md_op = 2'b10;
        #2;
        chk_ctl("br_ld_div_ctl", 5'b00110);
        next_cycle();
        idle_inputs();
        #2;
        check("br_ld_div_no_busy", bus.md_busy, 0);
        next_cycle();

        // Memory timeout: error appears after wait_cnt reaches 255 and stays sticky.
        bus.mem_req = 1'b1;
        for (int c = 1; c <= 256; c++) next_cycle();
        #2;
        check("timeout_not_yet", bus.mem_error, 0);
        next_cycle();
        #2;
        check("timeout_set", bus.mem_error, 1);
        chk_ctl("timeout_still_wait", 5'b11000);
        bus.mem_ack = 1'b1;
        next_cycle();
        idle_inputs();
        #2;
        check("timeout_sticky", bus.mem_error, 1);
        chk_ctl("timeout_back_run", 5'b00000);
        next_cycle();

        // Async reset in the middle of a divide and a memory wait.
        bus.id_md_op = 2'b10;
        #2;
        chk_ctl("div_start", 5'b00001);
        next_cycle();
        idle_inputs();
        next_cycle();
        next_cycle();
        bus.mem_req = 1'b1; bus.id_md_op = 2'b10;
        #2;
        check("div_busy_mid", bus.md_busy, 1);
        chk_ctl("div_mid_memwait", 5'b11000);
        next_cycle();
        #2;
        rst = 1'b1;
        #1;
        check("rst_mid_busy", bus.md_busy, 0);
        check("rst_mid_error", bus.mem_error, 0);
        check("rst_mid_done", bus.md_done, 0);
        chk_ctl("rst_mid_ctl", 5'b00000);
        next_cycle();
        idle_inputs();
        rst = 1'b0;
        #2;
        chk_ctl("post_rst_run", 5'b00000);
        next_cycle();
        #2;
        check("post_rst_no_pending", bus.md_busy, 0);
        check("post_rst_error", bus.mem_error, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
